sprite_loader: RTL



---
 rtl/sprite_loader_if.sv | 32 +++
 rtl/sprite_loader.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sprite_loader_if.sv
// Byte stream in from the UART receiver and the pixel write port out to the
// sprite memories, bundled so the loader and its neighbours share one port.
interface sprite_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  // Handshake: i_Rx_DV is a one-cycle valid strobe with no ready; the loader
  // always accepts. o_write_en is a one-cycle valid strobe the memory must take.
  logic                  i_Rx_DV;
  logic [7:0]            i_Rx_Byte;
  logic                  o_write_en;
  logic [ADDR_WIDTH-1:0] o_write_addr;
  logic [8:0]            o_write_data;
  logic                  o_mem_select;

  modport master (
    input  i_Rx_DV,
    input  i_Rx_Byte,
    output o_write_en,
    output o_write_addr,
    output o_write_data,
    output o_mem_select
  );

  modport slave (
    output i_Rx_DV,
    output i_Rx_Byte,
    input  o_write_en,
    input  o_write_addr,
    input  o_write_data,
    input  o_mem_select
  );
endinterface

// File: rtl/sprite_loader.sv
// Parses SYNC/SEL/pixel-pair/CHK packets from the UART and writes RGB333
// pixels into the frog or car sprite memory, with checksum and idle timeout.
module sprite_loader #(
  parameter int          TILE_SIZE      = 32,
  parameter int          DEPTH          = TILE_SIZE * TILE_SIZE,
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 250000
) (
  input  logic           i_Clk,
  input  logic           i_Reset,
  sprite_loader_if.master bus,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_error,
  output logic [1:0]     o_loaded,
  output logic [2:0]     o_state
);

  localparam int                    CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]         TO_LAST = CW'(TIMEOUT_CYCLES - 2);
  localparam logic [ADDR_WIDTH-1:0] A_LAST  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    PIX_HI = 3'd2,
    PIX_LO = 3'd3,
    CHECK  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            xor_q, xor_d;
  logic                  hi_q, hi_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sel_q, sel_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [8:0]            wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            loaded_q, loaded_d;

  logic timeout_hit;

  // Firing one count early means the error pulse lands on the same edge the
  // counter would reach TIMEOUT_CYCLES-1; a DV in that cycle is dropped.
  assign timeout_hit = (state_q != IDLE) && (cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    xor_d    = xor_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    loaded_d = loaded_q;

    if (state_q == IDLE) begin
      cnt_d = '0;
      if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC_BYTE)) begin
        state_d = SELECT;
        xor_d   = 8'h00;
      end
    end else if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = bus.i_Rx_DV ? '0 : cnt_q + CW'(1);
      if (bus.i_Rx_DV) begin
        case (state_q)
          SELECT: begin
            if (bus.i_Rx_Byte[7:1] == 7'd0) begin
              sel_d   = bus.i_Rx_Byte[0];
              addr_d  = '0;
              xor_d   = xor_q ^ bus.i_Rx_Byte;
              state_d = PIX_HI;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          PIX_HI: begin
            hi_d    = bus.i_Rx_Byte[0];
            xor_d   = xor_q ^ bus.i_Rx_Byte;
            state_d = PIX_LO;
          end
          PIX_LO: begin
            wen_d   = 1'b1;
            waddr_d = addr_q;
            wdata_d = {hi_q, bus.i_Rx_Byte};
            xor_d   = xor_q ^ bus.i_Rx_Byte;
            if (addr_q == A_LAST) begin
              state_d = CHECK;
            end else begin
              addr_d  = addr_q + ADDR_WIDTH'(1);
              state_d = PIX_HI;
            end
          end
          CHECK: begin
            if (bus.i_Rx_Byte == xor_q) begin
              done_d          = 1'b1;
              loaded_d[sel_q] = 1'b1;
            end else begin
              err_d           = 1'b1;
              loaded_d[sel_q] = 1'b0;
            end
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      xor_q    <= 8'h00;
      hi_q     <= 1'b0;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= 9'h000;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      loaded_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      xor_q    <= xor_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.o_write_en   = wen_q;
  assign bus.o_write_addr = waddr_q;
  assign bus.o_write_data = wdata_q;
  assign bus.o_mem_select = sel_q;
  assign o_busy           = (state_q != IDLE);
  assign o_done           = done_q;
  assign o_error          = err_q;
  assign o_loaded         = loaded_q;
  assign o_state          = state_q;

endmodule
